hilo_muldiv_ctrl: RTL and testbench

Multiply/divide sequencer and HI/LO register pair for the multicycle CPU. Sits directly upstream of the unsigned iterative divider (DIVU). It handles signed/unsigned operand conditioning, issues the start handshake and waits for busy. It then sign-corrects the results and writes HI/LO. MULT/MULTU use an internal iterative shift-add multiplier. The block stalls the CPU control unit until HI/LO are valid.

---
 rtl/hilo_muldiv_ctrl_pkg.sv | 22 ++
 rtl/hilo_muldiv_ctrl_if.sv | 21 ++
 rtl/hilo_muldiv_ctrl_seq_multiplier.sv | 51 +++++
 rtl/hilo_muldiv_ctrl.sv | 160 ++++++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared constants and state encoding for the HI/LO multiply/divide sequencer.
package hilo_muldiv_ctrl_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV_ISSUE,
        S_DIV_WAIT,
        S_FIX,
        S_DONE
    } state_t;

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// Handshake bus between the sequencer (master) and the unsigned iterative divider (slave).
interface hilo_muldiv_ctrl_if #(parameter int WIDTH = 32);

    logic [WIDTH-1:0] div_dividend;
    logic [WIDTH-1:0] div_divisor;
    logic             div_start;
    logic             div_busy;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] div_r;

    modport master (
        output div_dividend, div_divisor, div_start,
        input  div_busy, div_q, div_r
    );

    modport slave (
        input  div_dividend, div_divisor, div_start,
        output div_busy, div_q, div_r
    );

endinterface

// File: rtl/hilo_muldiv_ctrl_seq_multiplier.sv
// Unsigned iterative shift-add multiplier: one partial product per cycle, WIDTH steps.
// done is high during the final step, so product is complete on the following cycle.
module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;

    // Load operands on start, then add the shifted multiplicand for each set multiplier bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start) begin
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            if (mplier_q[0]) acc_q <= acc_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) busy_q <= 1'b0;
        end
    end

    assign busy    = busy_q;
    assign done    = busy_q && (cnt_q == CW'(WIDTH - 1));
    assign product = acc_q;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO multiply/divide sequencer. Conditions signed operands to magnitudes, runs the
// internal multiplier or drives the external unsigned divider, sign-corrects and writes HI/LO.
// Optional macro DIV_ZERO_EN: zero-divisor DIV/DIVU bypasses the divider, writes
// lo=all-ones, hi=raw rs_val and sets the sticky dz_flag.
module hilo_muldiv_ctrl
    import hilo_muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               op_valid,
    input  logic [2:0]         op_code,
    input  logic [WIDTH-1:0]   rs_val,
    input  logic [WIDTH-1:0]   rt_val,
    output logic               stall,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    hilo_muldiv_ctrl_if.master div,
    output logic               dz_flag
);

    state_t             state_q;
    logic               neg_q_q, neg_r_q, is_div_q, dz_path_q;
    logic               div_start_q, seen_busy_q;
    logic [WIDTH-1:0]   dividend_q, divisor_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic               is_signed, sa, sb, accept_md, mul_start, div_zero;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               mul_busy, mul_done;
    logic [2*WIDTH-1:0] product, prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix;

    assign is_signed = (op_code == OP_MULT) || (op_code == OP_DIV);
    assign sa        = is_signed & rs_val[WIDTH-1];
    assign sb        = is_signed & rt_val[WIDTH-1];
    assign mag_a     = sa ? (~rs_val + 1'b1) : rs_val;
    assign mag_b     = sb ? (~rt_val + 1'b1) : rt_val;
    assign accept_md = (state_q == S_IDLE) && op_valid && (op_code <= OP_DIVU);
    assign mul_start = accept_md && !op_code[1];

    // The CPU sees the stall in the accept cycle itself so the instruction is held.
    assign stall = ((state_q != S_IDLE) && (state_q != S_DONE)) || accept_md;

`ifdef DIV_ZERO_EN
    logic dz_flag_q;
    assign div_zero = (rt_val == '0);
    assign dz_flag  = dz_flag_q;

    // Sticky divide-by-zero indicator, set when the bypass result is written.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                               dz_flag_q <= 1'b0;
        else if ((state_q == S_FIX) && dz_path_q) dz_flag_q <= 1'b1;
    end
`else
    assign div_zero = 1'b0;
    assign dz_flag  = 1'b0;
`endif

    seq_multiplier #(.WIDTH(WIDTH)) u_mul (
        .clock   (clock),
        .reset   (reset),
        .start   (mul_start),
        .a       (mag_a),
        .b       (mag_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (product)
    );

    assign prod_fix = neg_q_q ? (~product + 1'b1) : product;
    assign q_fix    = neg_q_q ? (~div.div_q + 1'b1) : div.div_q;
    assign r_fix    = neg_r_q ? (~div.div_r + 1'b1) : div.div_r;

    // Sequencer FSM with registered divider handshake and HI/LO writes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            is_div_q    <= 1'b0;
            dz_path_q   <= 1'b0;
            div_start_q <= 1'b0;
            seen_busy_q <= 1'b0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (op_valid) begin
                        case (op_code)
                            OP_MTHI: hi_q <= rs_val;
                            OP_MTLO: lo_q <= rs_val;
                            OP_MULT, OP_MULTU: begin
                                neg_q_q  <= sa ^ sb;
                                neg_r_q  <= sa;
                                is_div_q <= 1'b0;
                                state_q  <= S_MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                neg_q_q  <= sa ^ sb;
                                neg_r_q  <= sa;
                                is_div_q <= 1'b1;
                                divisor_q <= mag_b;
                                if (div_zero) begin
                                    // Bypass keeps the raw dividend for the hi write.
                                    dz_path_q  <= 1'b1;
                                    dividend_q <= rs_val;
                                    state_q    <= S_FIX;
                                end else begin
                                    dividend_q  <= mag_a;
                                    div_start_q <= 1'b1;
                                    seen_busy_q <= 1'b0;
                                    state_q     <= S_DIV_ISSUE;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (mul_done || !mul_busy) state_q <= S_FIX;
                end
                S_DIV_ISSUE: begin
                    div_start_q <= 1'b0;
                    state_q     <= S_DIV_WAIT;
                end
                S_DIV_WAIT: begin
                    if (div.div_busy) seen_busy_q <= 1'b1;
                    if (!div.div_busy && seen_busy_q) state_q <= S_FIX;
                end
                S_FIX: begin
                    if (dz_path_q) begin
                        lo_q <= '1;
                        hi_q <= dividend_q;
                    end else if (is_div_q) begin
                        lo_q <= q_fix;
                        hi_q <= r_fix;
                    end else begin
                        {hi_q, lo_q} <= prod_fix;
                    end
                    dz_path_q <= 1'b0;
                    state_q   <= S_DONE;
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign hi               = hi_q;
    assign lo               = lo_q;
    assign div.div_start    = div_start_q;
    assign div.div_dividend = dividend_q;
    assign div.div_divisor  = divisor_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Scoreboard bench for hilo_muldiv_ctrl with a behavioural 33-cycle divider.
module tb_hilo_muldiv_ctrl;

    localparam int W = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          op_valid;
    logic [2:0]    op_code;
    logic [W-1:0]  rs_val, rt_val;
    logic          stall;
    logic [W-1:0]  hi, lo;
    logic          dz_flag;

    hilo_muldiv_ctrl_if #(.WIDTH(W)) dif ();

    hilo_muldiv_ctrl #(.WIDTH(W)) dut (
        .clock    (clock),
        .reset    (reset),
        .op_valid (op_valid),
        .op_code  (op_code),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .stall    (stall),
        .hi       (hi),
        .lo       (lo),
        .div      (dif),
        .dz_flag  (dz_flag)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        bit          dz;
        int          stall_len;
        int          starts;
        bit          chk_div;
        logic [31:0] dd;
        logic [31:0] dv;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          start_cnt = 0;
    bit          mt_chk = 0;
    logic [31:0] last_dd = 0, last_dv = 0;
    logic [31:0] m_hi = 0, m_lo = 0;
    bit          m_dz = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference: results straight from signed/unsigned arithmetic on the operands.
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa, sbv, qq, rr, p;
        logic [63:0] pu;
        e.stall_len = 0; e.starts = start_cnt; e.chk_div = 0; e.dd = 0; e.dv = 0;
        case (op)
            3'd0: begin
                sa = $signed(a); sbv = $signed(b); p = sa * sbv;
                pu = 64'(p); m_hi = pu[63:32]; m_lo = pu[31:0]; e.stall_len = 34;
            end
            3'd1: begin
                pu = 64'(a) * 64'(b); m_hi = pu[63:32]; m_lo = pu[31:0]; e.stall_len = 34;
            end
            3'd2, 3'd3: begin
                if (b == 0) begin
`ifdef DIV_ZERO_EN
                    m_lo = 32'hFFFF_FFFF; m_hi = a; m_dz = 1; e.stall_len = 2;
`else
                    // Divider yields all-ones quotient and the dividend as remainder.
                    m_lo = (op == 3'd2 && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
                    m_hi = a; e.stall_len = 37; e.starts = start_cnt + 1; e.chk_div = 1;
                    e.dd = (op == 3'd2 && a[31]) ? -a : a; e.dv = 0;
`endif
                end else begin
                    if (op == 3'd2) begin
                        sa = $signed(a); sbv = $signed(b); qq = sa / sbv; rr = sa - qq * sbv;
                        pu = 64'(qq); m_lo = pu[31:0]; pu = 64'(rr); m_hi = pu[31:0];
                        e.dd = a[31] ? -a : a; e.dv = b[31] ? -b : b;
                    end else begin
                        m_lo = a / b; m_hi = a % b; e.dd = a; e.dv = b;
                    end
                    e.stall_len = 37; e.starts = start_cnt + 1; e.chk_div = 1;
                end
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: ;
        endcase
        e.hi = m_hi; e.lo = m_lo; e.dz = m_dz;
        return e;
    endfunction

    // Behavioural divider: busy for 33 cycles after a start pulse, then presents q/r.
    initial begin
        logic [31:0] dd, dv;
        dif.div_busy = 0; dif.div_q = 0; dif.div_r = 0;
        forever begin
            @(negedge clock);
            if (dif.div_start && !reset) begin
                start_cnt++;
                dd = dif.div_dividend; dv = dif.div_divisor;
                last_dd = dd; last_dv = dv;
                @(posedge clock); #1;
                dif.div_busy = 1;
                repeat (33) @(posedge clock);
                #1;
                dif.div_busy = 0;
                dif.div_q = (dv == 0) ? 32'hFFFF_FFFF : dd / dv;
                dif.div_r = (dv == 0) ? dd : dd % dv;
            end
        end
    end

    // Monitor: pops an expectation whenever stall falls or an MTHI/MTLO has landed.
    initial begin
        int   run = 0;
        bit   prev = 0;
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset) begin
                run = 0; prev = 0;
            end else begin
                if (mt_chk) begin
                    mt_chk = 0;
                    if (sb_q.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
                    else begin
                        e = sb_q.pop_front();
                        chk("mt_hi", 64'(hi), 64'(e.hi));
                        chk("mt_lo", 64'(lo), 64'(e.lo));
                    end
                end else if (prev && !stall) begin
                    if (sb_q.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
                    else begin
                        e = sb_q.pop_front();
                        chk("hi", 64'(hi), 64'(e.hi));
                        chk("lo", 64'(lo), 64'(e.lo));
                        chk("dz_flag", 64'(dz_flag), 64'(e.dz));
                        chk("stall_len", 64'(run), 64'(e.stall_len));
                        chk("div_starts", 64'(start_cnt), 64'(e.starts));
                        if (e.chk_div) begin
                            chk("div_dividend", 64'(last_dd), 64'(e.dd));
                            chk("div_divisor", 64'(last_dv), 64'(e.dv));
                        end
                    end
                end
                if (stall) run++; else run = 0;
                prev = stall;
            end
        end
    end

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int k;
        @(posedge clock); #1;
        op_code = op; rs_val = a; rt_val = b; op_valid = 1;
        sb_q.push_back(model(op, a, b));
        if (op >= 3'd4) begin
            @(posedge clock); #1;
            op_valid = 0; mt_chk = 1;
            @(negedge clock);
        end else begin
            for (k = 0; k < 200; k++) begin
                @(negedge clock);
                if (!stall) break;
            end
            if (k == 200) chk("stall_timeout", 64'd1, 64'd0);
            // Request stays asserted through DONE; it must not start a second operation.
            @(posedge clock); #1;
            op_valid = 0;
            @(negedge clock);
            chk("no_reissue", 64'(stall), 64'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        logic [2:0]  op;
        reset = 1; op_valid = 0; op_code = 0; rs_val = 0; rt_val = 0;
        repeat (3) @(negedge clock);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_start", 64'(dif.div_start), 64'd0);
        chk("rst_dividend", 64'(dif.div_dividend), 64'd0);
        chk("rst_divisor", 64'(dif.div_divisor), 64'd0);
        chk("rst_dz", 64'(dz_flag), 64'd0);
        @(posedge clock); #1; reset = 0;

        do_op(3'd0, 32'hFFFF_FFFD, 32'd7);
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(3'd2, 32'hFFFF_FFF9, 32'd2);
        do_op(3'd3, 32'd100, 32'd7);
        do_op(3'd4, 32'h1234_5678, 32'd0);
        do_op(3'd5, 32'hCAFE_F00D, 32'd0);
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(3'd0, 32'h8000_0000, 32'h8000_0000);

        // Reserved op codes leave everything untouched.
        @(posedge clock); #1; op_code = 3'd6; rs_val = 32'hDEAD_BEEF; op_valid = 1;
        @(negedge clock); chk("op6_stall", 64'(stall), 64'd0);
        @(posedge clock); #1; op_valid = 0;
        @(negedge clock);
        chk("op6_hi", 64'(hi), 64'(m_hi));
        chk("op6_lo", 64'(lo), 64'(m_lo));

        do_op(3'd3, 32'd5, 32'd0);

        // Abort a multiply partway through with reset.
        @(posedge clock); #1;
        op_code = 3'd0; rs_val = 32'd1234; rt_val = 32'd5678; op_valid = 1;
        sb_q.push_back(model(3'd0, 32'd1234, 32'd5678));
        @(negedge clock);
        repeat (10) @(posedge clock);
        #1;
        void'(sb_q.pop_back());
        reset = 1; op_valid = 0; m_hi = 0; m_lo = 0; m_dz = 0;
        @(negedge clock);
        chk("abort_stall", 64'(stall), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        chk("abort_start", 64'(dif.div_start), 64'd0);
        @(posedge clock); #1; reset = 0;
        do_op(3'd0, 32'd6, 32'd7);

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 5));
            case ($urandom_range(0, 3))
                0:       a = 32'h8000_0000;
                1:       a = 32'($urandom_range(0, 20)) - 32'd10;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 9));
                default: b = $urandom;
            endcase
            do_op(op, a, b);
        end

        repeat (5) @(negedge clock);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
